// File: rtl/mdu_e.sv
// Iterative multiply/divide unit for the E stage: MULT/MULTU/DIV/DIVU into HI/LO over 33 cycles.
// Also holds the architectural HI/LO registers, which MTHI/MTLO can write at any time.
module mdu_e (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_e,
   input  logic [1:0]  op_e,
   input  logic [31:0] srca_e,
   input  logic [31:0] srcb_e,
   input  logic        wr_hi_w,
   input  logic        wr_lo_w,
   input  logic [31:0] wdata_w,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   // state | meaning
   // IDLE  | waiting for start_e; HI/LO hold last result
   // RUN   | one shift-add / restoring-divide step per edge, count 0..31
   // FIN   | sign fix-up, HI/LO write, done pulse
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic        sign_a_q, sign_a_d;
   logic        sign_b_q, sign_b_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] acc_q, acc_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        in_signed;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix, a_orig;

   always_comb begin
      in_signed = ~op_e[0];
      a_mag     = (in_signed && srca_e[31]) ? 32'd0 - srca_e : srca_e;
      b_mag     = (in_signed && srcb_e[31]) ? 32'd0 - srcb_e : srcb_e;

      // Multiply: acc = {partial product, remaining multiplier bits}
      mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
      // Divide: acc = {partial remainder, remaining dividend / quotient bits}
      div_shift = acc_q[63:31];
      div_diff  = div_shift - {1'b0, b_q};

      // Signs are latched as zero for unsigned ops, so one fix-up path serves all four
      prod_fix  = (sign_a_q ^ sign_b_q) ? 64'd0 - acc_q : acc_q;
      quot_fix  = (sign_a_q ^ sign_b_q) ? 32'd0 - acc_q[31:0] : acc_q[31:0];
      rem_fix   = sign_a_q ? 32'd0 - acc_q[63:32] : acc_q[63:32];
      a_orig    = sign_a_q ? 32'd0 - a_q : a_q;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      count_d  = count_q;
      hi_d     = wr_hi_w ? wdata_w : hi_q;
      lo_d     = wr_lo_w ? wdata_w : lo_q;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_e) begin
               op_d     = op_e;
               sign_a_d = in_signed & srca_e[31];
               sign_b_d = in_signed & srcb_e[31];
               a_d      = a_mag;
               b_d      = b_mag;
               acc_d    = {32'd0, op_e[1] ? a_mag : b_mag};
               count_d  = 5'd0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (op_q[1]) begin
               if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
               else               acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
            end
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) state_d = FIN;
         end
         FIN: begin
            if (!op_q[1]) begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end else if (b_q == 32'd0) begin
               hi_d = a_orig;
               lo_d = 32'hFFFF_FFFF;
            end else begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= 2'b00;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         acc_q    <= 64'd0;
         count_q  <= 5'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_mdu_e.sv
// Directed bench for mdu_e: hand-computed HI/LO results, latency, done pulse,
// ignored restart, MTLO during RUN and synchronous reset mid-operation.
module tb_mdu_e;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_e;
   logic [1:0]  op_e;
   logic [31:0] srca_e, srcb_e;
   logic        wr_hi_w, wr_lo_w;
   logic [31:0] wdata_w;
   logic [31:0] hi, lo;
   logic        busy, done;

   int checks = 0;
   int errors = 0;
   int n;

   mdu_e dut (
      .clk     (clk),
      .reset   (reset),
      .start_e (start_e),
      .op_e    (op_e),
      .srca_e  (srca_e),
      .srcb_e  (srcb_e),
      .wr_hi_w (wr_hi_w),
      .wr_lo_w (wr_lo_w),
      .wdata_w (wdata_w),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic begin_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start_e = 1'b1;
      op_e    = op;
      srca_e  = a;
      srcb_e  = b;
      @(posedge clk); #1;
      start_e = 1'b0;
      n = 1;
      check("busy_after_start", {63'd0, busy}, 64'd1);
   endtask

   task automatic step;
      @(posedge clk); #1;
      if (busy === 1'b1) n++;
   endtask

   task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el);
      while (busy === 1'b1 && n < 40) step();
      check({tag, "_cycles"}, 64'(n), 64'd33);
      check({tag, "_done"}, {63'd0, done}, 64'd1);
      check({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
      check({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
      @(posedge clk); #1;
      check({tag, "_done_low"}, {63'd0, done}, 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      begin_op(op, a, b);
      wait_done(tag, eh, el);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      start_e = 1'b0;
      op_e    = 2'b00;
      srca_e  = 32'd0;
      srcb_e  = 32'd0;
      wr_hi_w = 1'b0;
      wr_lo_w = 1'b0;
      wdata_w = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      @(negedge clk) reset = 1'b0;

      @(negedge clk);
      wr_hi_w = 1'b1;
      wdata_w = 32'h1234_5678;
      @(posedge clk); #1;
      wr_hi_w = 1'b0;
      check("mthi_idle", {32'd0, hi}, 64'h1234_5678);
      check("mthi_lo_kept", {32'd0, lo}, 64'd0);

      run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_neg",  MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mult_min",  MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run_op("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_negb",  DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
      run_op("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
      run_op("divu_zero", DIVU,  32'd1234,      32'd0,         32'd1234,      32'hFFFF_FFFF);
      run_op("div_zero",  DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("divu",      DIVU,  32'd100,       32'd7,         32'd2,         32'd14);

      // Restart during RUN is ignored; MTLO mid-RUN is visible until FIN overwrites it
      begin_op(MULTU, 32'd6, 32'd7);
      @(negedge clk);
      start_e = 1'b1;
      op_e    = DIVU;
      srca_e  = 32'd100;
      srcb_e  = 32'd3;
      step();
      start_e = 1'b0;
      repeat (9) step();
      @(negedge clk);
      wr_lo_w = 1'b1;
      wdata_w = 32'h55;
      step();
      wr_lo_w = 1'b0;
      check("mtlo_run_lo", {32'd0, lo}, 64'h55);
      check("run_hi_stable", {32'd0, hi}, 64'd2);
      check("mtlo_run_busy", {63'd0, busy}, 64'd1);
      wait_done("restart_ign", 32'd0, 32'd42);

      // Synchronous reset during RUN aborts the operation
      begin_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (20) step();
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check("rst_run_busy", {63'd0, busy}, 64'd0);
      check("rst_run_done", {63'd0, done}, 64'd0);
      check("rst_run_hi", {32'd0, hi}, 64'd0);
      check("rst_run_lo", {32'd0, lo}, 64'd0);
      @(negedge clk) reset = 1'b0;
      run_op("multu_after_rst", MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_e.md
# mdu_e

Execute-stage multiply/divide unit for the pipelined MIPS core. Sits directly downstream of the decode/execute pipeline register: takes the forwarded E-stage operands of MULT/MULTU/DIV/DIVU and computes iteratively into the architectural HI/LO registers over 33 cycles. Exposes `busy` to the hazard unit so dependent HI/LO or multiply/divide instructions stall in D, and read ports for MFHI/MFLO.

## Interface

Parameters:
- none (32-bit datapath fixed)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start_e  in  1  multiply/divide instruction valid in E this cycle (already gated by flush_e upstream)
- op_e  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srca_e  in  32  forwarded rs operand (multiplicand / dividend)
- srcb_e  in  32  forwarded rt operand (multiplier / divisor)
- wr_hi_w  in  1  MTHI write from W stage
- wr_lo_w  in  1  MTLO write from W stage
- wdata_w  in  32  MTHI/MTLO data
- hi  out  32  HI register (MFHI source)
- lo  out  32  LO register (MFLO source)
- busy  out  1  registered; high while an operation is in flight
- done  out  1  registered one-cycle pulse after HI/LO updated by an operation

## Operation

- States: IDLE, RUN, FIN. `busy` = (state != IDLE).
- IDLE: `start_e`=1 at an edge -> latch op, signs, operand magnitudes (|x| for signed ops, raw for unsigned), clear 64-bit accumulator/remainder, count=0, -> RUN. `start_e` ignored in RUN/FIN.
- RUN: one iteration per edge, 32 edges, count 0..31; count==31 edge -> FIN.
  - Multiply: shift-add on magnitudes, 64-bit unsigned product.
  - Divide: restoring, one quotient bit per edge, 32-bit unsigned quotient/remainder.
- FIN (one edge): sign fix-up, write HI/LO, pulse `done`, -> IDLE.
  - MULT: product negated if sign(a)^sign(b); HI=prod[63:32], LO=prod[31:0].
  - MULTU: HI/LO = unsigned product.
  - DIV: LO=quotient negated if sign(a)^sign(b); HI=remainder negated if sign(a) (remainder sign follows dividend).
  - DIVU: LO=quotient, HI=remainder.
  - Divide by zero (both DIV/DIVU): same latency, LO=32'hFFFF_FFFF, HI=srca as latched.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0 (magnitude arithmetic, no trap).
- MTHI/MTLO: `wr_hi_w`/`wr_lo_w` write `wdata_w` at edge in any state; FIN write has priority in same edge and overwrites any value written during RUN.
- Hazard contract (hazard unit): stall D when D holds MFHI/MFLO/MULT*/DIV* and (`busy` or `start_e`).

## Timing

- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, count=0; reset mid-RUN/FIN aborts, HI/LO not updated.
- Start sampled edge E0; busy=1 after E0 through E33; HI/LO valid and done=1 after E33; busy=0 after E33.
- Total: 33 busy cycles; next start accepted at E33 edge earliest? No — earliest accepted start is the edge after E33 (state must be IDLE when sampled).
- `hi`/`lo` change only at FIN edge, MTHI/MTLO edge, or reset; stable during RUN (old values readable).
- done high exactly one cycle per completed operation.

## Test plan

- MULTU 0xFFFF_FFFF x 0xFFFF_FFFF, start at E0 -> busy high 33 cycles, after E33 HI=0xFFFF_FFFE, LO=0x0000_0001, done one cycle.
- MULT -3 x 7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; MULT 0x8000_0000 x 0x8000_0000 -> HI=0x4000_0000, LO=0.
- DIV -7 / 2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU 100 / 7 -> LO=14, HI=2; DIV 0x8000_0000 / -1 -> LO=0x8000_0000, HI=0.
- DIVU 1234 / 0 -> after 33 cycles LO=0xFFFF_FFFF, HI=1234.
- start_e pulsed again during RUN with different operands -> ignored, result of first op only; MTLO 0x55 at RUN cycle 10 -> lo=0x55 until FIN, then overwritten.
- reset asserted at RUN cycle 20 -> next cycle busy=0, done=0, hi=lo=0; new MULTU 3x5 then completes with LO=15, HI=0.
